// File: rtl/fir_pkg.sv
// Shared state encoding and width helpers for the fir_tap_mac output stage.
// Optional output clamping is selected by FIR_TAP_MAC_SAT_EN (see fir_round_sat).
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Full-precision product plus log2(TAPS) bits of accumulation growth.
  function automatic int acc_width(input int w_in, input int c_in, input int taps);
    return w_in + c_in + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Rounding right-shift and width reduction of the MAC sum. Clamps to the output
// range when FIR_TAP_MAC_SAT_EN is defined, otherwise wraps (two's complement).
module fir_round_sat #(
  parameter int ACC_W = 14,
  parameter int SHIFT = 0,
  parameter int Y_OUT = 20
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [Y_OUT-1:0] y,
  output logic                    sat
);
  // One guard bit so adding the rounding constant can never overflow.
  localparam int SUM_W = ACC_W + 1;

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] r;

  if (SHIFT > 0) begin : g_round
    localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) << (SHIFT - 1);
    always_comb begin
      sum = SUM_W'(acc) + HALF;
      r   = sum >>> SHIFT;
    end
  end else begin : g_pass
    always_comb begin
      sum = SUM_W'(acc);
      r   = sum;
    end
  end

  if (Y_OUT >= SUM_W) begin : g_wide
    assign y   = Y_OUT'(r);
    assign sat = 1'b0;
  end else begin : g_narrow
`ifdef FIR_TAP_MAC_SAT_EN
    localparam logic signed [SUM_W-1:0] Y_MAX = {{(SUM_W-Y_OUT+1){1'b0}}, {(Y_OUT-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] Y_MIN = {{(SUM_W-Y_OUT+1){1'b1}}, {(Y_OUT-1){1'b0}}};
    always_comb begin
      y   = r[Y_OUT-1:0];
      sat = 1'b0;
      if (r > Y_MAX) begin
        y   = Y_MAX[Y_OUT-1:0];
        sat = 1'b1;
      end else if (r < Y_MIN) begin
        y   = Y_MIN[Y_OUT-1:0];
        sat = 1'b1;
      end
    end
`else
    // Bits above the output width are dropped by design in wrap mode.
    logic unused_hi;
    assign unused_hi = ^r[SUM_W-1:Y_OUT];
    assign y         = r[Y_OUT-1:0];
    assign sat       = 1'b0;
`endif
  end

endmodule

// File: rtl/fir_tap_mac.sv
// Time-multiplexed FIR tap stage: delay line, double-buffered coefficients and one
// shared MAC, one result per accepted sample. FIR_TAP_MAC_SAT_EN enables clamping.
module fir_tap_mac
  import fir_pkg::*;
#(
  parameter  int W_IN  = 7,
  parameter  int C_IN  = 5,
  parameter  int TAPS  = 4,
  parameter  int Y_OUT = 20,
  parameter  int SHIFT = 0,
  localparam int AW    = clog2(TAPS),
  localparam int ACC_W = acc_width(W_IN, C_IN, TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_IN-1:0]  in_data,
  input  logic                    coef_we,
  input  logic [AW-1:0]           coef_addr,
  input  logic signed [C_IN-1:0]  coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [Y_OUT-1:0] out_data,
  output logic                    out_sat,
  output logic                    busy
);
  localparam int            P_W  = W_IN + C_IN;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  fir_state_e              state_q, state_d;
  logic signed [W_IN-1:0]  d_q     [TAPS];
  logic signed [W_IN-1:0]  d_d     [TAPS];
  logic signed [C_IN-1:0]  c_sh_q  [TAPS];
  logic signed [C_IN-1:0]  c_sh_d  [TAPS];
  logic signed [C_IN-1:0]  c_act_q [TAPS];
  logic signed [C_IN-1:0]  c_act_d [TAPS];
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [AW-1:0]           idx_q, idx_d;
  logic signed [Y_OUT-1:0] out_data_q, out_data_d, rs_y;
  logic                    out_sat_q, out_sat_d, rs_sat;
  logic signed [P_W-1:0]   prod;

  fir_round_sat #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT),
    .Y_OUT(Y_OUT)
  ) u_round_sat (
    .acc(acc_sum),
    .y  (rs_y),
    .sat(rs_sat)
  );

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    c_sh_d     = c_sh_q;
    c_act_d    = c_act_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    prod    = P_W'(d_q[idx_q]) * P_W'(c_act_q[idx_q]);
    acc_sum = acc_q + ACC_W'(prod);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          d_d[0] = in_data;
          for (int k = 1; k < TAPS; k++) d_d[k] = d_q[k-1];
          c_act_d = c_sh_q;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          out_data_d = rs_y;
          out_sat_d  = rs_sat;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Shadow write is applied after the accept-time copy, so it affects the next sample.
    if (coef_we && (int'(coef_addr) < TAPS)) c_sh_d[coef_addr] = coef_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        d_q[k]     <= '0;
        c_sh_q[k]  <= '0;
        c_act_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      c_sh_q     <= c_sh_d;
      c_act_q    <= c_act_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Scoreboard bench for fir_tap_mac: a wide (Y_OUT=20) and a narrow (Y_OUT=8) instance
// share stimulus; expected results come from a sample-history dot-product model.
`timescale 1ns/1ps
module tb_fir_tap_mac;
  localparam int W_IN = 7;
  localparam int C_IN = 5;
  localparam int TAPS = 4;
  localparam int AW   = 2;
  localparam int YA   = 20;
  localparam int YB   = 8;
  localparam int LAT  = TAPS + 1;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic signed [W_IN-1:0] in_data;
  logic                   coef_we;
  logic [AW-1:0]          coef_addr;
  logic signed [C_IN-1:0] coef_data;
  logic                   out_ready;
  logic                   in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic                   out_sat_a, out_sat_b, busy_a, busy_b;
  logic signed [YA-1:0]   out_data_a;
  logic signed [YB-1:0]   out_data_b;

  fir_tap_mac #(.W_IN(W_IN), .C_IN(C_IN), .TAPS(TAPS), .Y_OUT(YA), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_sat(out_sat_a), .busy(busy_a)
  );

  fir_tap_mac #(.W_IN(W_IN), .C_IN(C_IN), .TAPS(TAPS), .Y_OUT(YB), .SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_sat(out_sat_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ya;
    int sa;
    int yb;
    int sb;
    int acc_cyc;
  } exp_t;

  exp_t sbq[$];
  int   hist[TAPS];
  int   sh[TAPS];
  int   act[TAPS];
  int   cyc;
  int   n_chk;
  int   n_fail;
  bit   shown;
  bit   head_seen;
  bit   rand_ready;

  function automatic void check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Narrow output: clamp or wrap the exact sum into YB bits.
  function automatic void narrow(input int s, output int y, output int sat);
    int hi, lo, w;
    hi = (1 << (YB - 1)) - 1;
    lo = -(1 << (YB - 1));
`ifdef FIR_TAP_MAC_SAT_EN
    if (s > hi) begin y = hi; sat = 1; end
    else if (s < lo) begin y = lo; sat = 1; end
    else begin y = s; sat = 0; end
`else
    w = ((s % (1 << YB)) + (1 << YB)) % (1 << YB);
    if (w > hi) w = w - (1 << YB);
    y = w;
    sat = 0;
`endif
  endfunction

  // Reference model: runs at every rising edge using the inputs the DUT samples.
  initial begin
    exp_t e;
    int   s;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        sbq.delete();
        head_seen = 0;
        for (int k = 0; k < TAPS; k++) begin hist[k] = 0; sh[k] = 0; act[k] = 0; end
      end else begin
        if (shown && out_ready) begin
          void'(sbq.pop_front());
          head_seen = 0;
        end else if (in_valid && sbq.size() == 0) begin
          for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = in_data;
          act = sh;
          s = 0;
          for (int k = 0; k < TAPS; k++) s += hist[k] * act[k];
          e.ya = s;
          e.sa = 0;
          narrow(s, e.yb, e.sb);
          e.acc_cyc = cyc - 1;
          sbq.push_back(e);
          head_seen = 0;
        end
        if (coef_we && int'(coef_addr) < TAPS) sh[coef_addr] = coef_data;
      end
    end
  end

  // Monitor: compares whatever the DUTs present against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      shown = 0;
      if (!rst) begin
        check("in_ready_a", in_ready_a, int'(sbq.size() == 0));
        check("in_ready_b", in_ready_b, int'(sbq.size() == 0));
        check("busy_a", busy_a, int'(sbq.size() != 0));
        if (out_valid_a || out_valid_b) begin
          if (sbq.size() == 0) begin
            check("spurious_out_valid", 1, 0);
          end else begin
            if (!head_seen) begin
              check("latency", cyc - sbq[0].acc_cyc, LAT);
              head_seen = 1;
            end
            check("out_valid_a", out_valid_a, 1);
            check("out_valid_b", out_valid_b, 1);
            check("out_data_a", out_data_a, sbq[0].ya);
            check("out_sat_a", out_sat_a, sbq[0].sa);
            check("out_data_b", out_data_b, sbq[0].yb);
            check("out_sat_b", out_sat_b, sbq[0].sb);
            shown = 1;
          end
        end else if (sbq.size() > 0 && !head_seen && (cyc - sbq[0].acc_cyc) > LAT) begin
          check("out_valid_timeout", 0, 1);
          head_seen = 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wr_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = C_IN'(v);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    wr_coef(0, c0);
    wr_coef(1, c1);
    wr_coef(2, c2);
    wr_coef(3, c3);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready_a && n < 200) begin tick(); n++; end
    if (n >= 200) check("accept_timeout", 0, 1);
  endtask

  task automatic send(input int s);
    in_valid = 1'b1;
    in_data  = W_IN'(s);
    wait_ready();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    if (!rand_ready) out_ready = 1'b1;
    while (sbq.size() != 0 && n < 300) begin tick(); n++; end
    if (n >= 300) check("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid_a, 0);
    check({tag, "_out_data"}, out_data_a, 0);
    check({tag, "_out_sat"}, out_sat_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_out_valid_b"}, out_valid_b, 0);
    check({tag, "_out_data_b"}, out_data_b, 0);
    check({tag, "_busy_b"}, busy_b, 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    shown = 0;
    head_seen = 0;
    rand_ready = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;

    tick();
    tick();
    check_reset_state("reset");
    check("in_ready_during_rst", in_ready_a, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready_a, 1);

    // Impulse response
    load(1, 2, 3, 4);
    send(1);
    for (int i = 0; i < 4; i++) send(0);
    drain();

    // Extreme values
    load(-16, -16, -16, -16);
    for (int i = 0; i < 4; i++) send(-64);
    drain();

    // Narrow-output overflow: 4 * 63 * 15 = 3780
    load(15, 15, 15, 15);
    for (int i = 0; i < 4; i++) send(63);
    drain();

    // Backpressure: result held while a further sample waits
    out_ready = 1'b0;
    send(5);
    in_valid = 1'b1;
    in_data  = W_IN'(9);
    repeat (LAT + 10) tick();
    check("bp_out_valid_held", out_valid_a, 1);
    check("bp_in_ready_low", in_ready_a, 0);
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid_a, 0);
    check("bp_release_in_ready", in_ready_a, 1);
    send(9);
    drain();

    // Coefficient write during ACC
    load(1, 1, 1, 1);
    send(10);
    wr_coef(0, 7);
    drain();
    send(3);
    drain();

    // Coefficient write in the same cycle as an accept
    wait_ready();
    in_valid  = 1'b1;
    in_data   = W_IN'(4);
    coef_we   = 1'b1;
    coef_addr = AW'(1);
    coef_data = C_IN'(-5);
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    drain();
    send(2);
    drain();

    // Reset in the middle of accumulation
    send(20);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    load(2, -3, 4, -5);
    send(11);
    send(-7);
    send(30);
    drain();

    // Randomised traffic with random backpressure and coefficient updates
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0)
        wr_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 31)) - 16);
      send(int'($urandom_range(0, 127)) - 64);
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_mac.md
# fir_tap_mac

Parametrised, time-multiplexed FIR output stage for the DWT filter bank: a TAPS-deep sample delay line, a loadable double-buffered coefficient bank and one shared signed multiplier-accumulator that produces one filtered output per accepted input sample. It generalises the fixed 4-tap, single-cycle combinational polyphase stages. It adds configurable tap count, rounding shift, valid/ready handshakes on both sides and optional output saturation. It sits between the polyphase sample splitter and the DWT band combiner.

## Interface
- `W_IN`, default 7: signed input sample width.
- `C_IN`, default 5: signed coefficient width.
- `TAPS`, default 4: filter length, ≥2.
- `Y_OUT`, default 20: signed output width.
- `SHIFT`, default 0: rounding right-shift applied to the accumulator.
- Derived localparams: `AW = clog2(TAPS)`; `ACC_W = W_IN + C_IN + AW`.

Ports:
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: input sample valid.
- `in_ready` output, 1 bit: block accepts a sample.
- `in_data` input, `W_IN` bits: signed sample.
- `coef_we` input, 1 bit: coefficient write strobe.
- `coef_addr` input, `AW` bits: tap index; values ≥ `TAPS` are ignored.
- `coef_data` input, `C_IN` bits: signed coefficient.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: downstream accepts the result.
- `out_data` output, `Y_OUT` bits: signed result.
- `out_sat` output, 1 bit: current result was clamped.
- `busy` output, 1 bit: state is not IDLE.

## Operation
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, shift the delay line: `d[0] <= in_data`, `d[k] <= d[k-1]`.
  - In the same cycle, copy the shadow coefficient bank to the active bank, clear `acc` and `idx`, and go to ACC.
- ACC:
  - Each cycle, `acc <= acc + d[idx]*c_act[idx]`. The product is a full-precision signed value of `W_IN+C_IN` bits, sign-extended to `ACC_W`.
  - `idx` increments each cycle.
  - On the cycle with `idx == TAPS-1`, the final sum passes through round/saturate, is registered into `out_data`/`out_sat`, and the FSM goes to OUT.
- OUT:
  - `out_valid` = 1. `out_data` and `out_sat` are held stable until `out_valid && out_ready`, then the FSM goes to IDLE.
- Coefficient writes:
  - Writes always go to the shadow bank, in any state.
  - The active bank changes only at sample accept.
  - A write in the same cycle as an accept lands in the shadow bank after the copy, so it applies from the next sample onward.
- Round/shift:
  - If `SHIFT > 0`: `r = (acc + (1 << (SHIFT-1))) >>> SHIFT`.
  - Otherwise `r = acc`.
- Width reduction of `r` to `Y_OUT`: see Configuration.
  - If `Y_OUT ≥` width of `r`, the result is sign-extended and `out_sat` = 0.

## Timing
- Reset values:
  - state IDLE, `busy` 0, `out_valid` 0, `out_data` 0, `out_sat` 0.
  - Delay line, both coefficient banks, `acc` and `idx` all 0.
  - `in_ready` is 0 while `rst` is high and 1 on the first cycle after reset.
- Latency: a sample accepted at cycle t gives `out_valid` = 1 at cycle t+TAPS+1.
- Throughput: with `out_ready` held high, one sample every TAPS+2 cycles.
- `in_ready` is low during ACC and OUT. Samples presented then are not consumed; the source holds them.
- Backpressure: the result is held indefinitely in OUT while `out_ready` = 0, and no new sample is accepted.
- Reset mid-operation (ACC or OUT): the partial accumulation is discarded, `out_valid` drops on the next cycle and all state returns to the reset values. Coefficients are cleared and must be reloaded.
- `in_valid` is sampled only in IDLE. `out_ready` is sampled only in OUT.

## Configuration
- Macro `FIR_TAP_MAC_SAT_EN`.
- Defined: `r` is clamped to [−2^(Y_OUT−1), 2^(Y_OUT−1)−1]. `out_sat` = 1 when a clamp occurred.
- Undefined: `out_data` takes the low `Y_OUT` bits of `r` (two's-complement wrap). `out_sat` is tied to 0.

## Structure
- Package `fir_pkg`:
  - FSM state enum.
  - `clog2` function.
  - `ACC_W` derivation helper.
- Sub-module `fir_round_sat`: purely combinational shift/round/clamp, parameterised by `ACC_W`, `SHIFT`, `Y_OUT`, containing the `FIR_TAP_MAC_SAT_EN` conditional.
- The top module holds the FSM, the delay line, both coefficient banks and the MAC.

## Test plan
All scenarios use default parameters unless stated.
- Impulse response: load c = {1,2,3,4}, feed samples 1,0,0,0,0 → outputs 1,2,3,4,0. Each `out_valid` rises exactly 5 cycles after its accept.
- Extreme values: c = {−16,−16,−16,−16}, four samples of −64 → fourth output +4096, `out_sat` 0.
- Saturation (`Y_OUT=8`, c all 15, four samples of 63; sum 3780):
  - With the macro: `out_data` = 127, `out_sat` = 1.
  - Without the macro: `out_data` = −60, `out_sat` = 0.
- Backpressure: hold `out_ready` = 0 for 10 cycles in OUT → `out_data` stable, `in_ready` 0, then one transfer and return to IDLE.
- Coefficient timing:
  - Write c[0] = 7 during ACC → current output unchanged, next output uses 7.
  - Write in the same cycle as an accept → the new value applies to the following sample.
- Reset mid-ACC: assert `rst` for 1 cycle at idx 2 → no output for that sample, all outputs at reset values, next sample after a coefficient reload is correct.
